// File: rtl/fixedpoint_mul.sv
// rtl/fixedpoint_mul.sv - iterative signed fixed-point multiplier with saturation.
// Optional: define FIXEDPOINT_MUL_ROUND_EN for round-half-away-from-zero instead of truncation.
module fixedpoint_mul #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH;
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] POS_MAX = (SW'(1) << (WIDTH - 1)) - SW'(1);
    localparam logic [SW-1:0] NEG_MAX = SW'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mag_a;
    logic [WIDTH-1:0] mag_b;
    logic            sign;
    logic [CW-1:0]   cnt;
    logic            busy_last;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [SW-1:0]   rsum;
    logic [SW-1:0]   m;
    logic [WIDTH-1:0] norm_data;
    logic            norm_ovf;

    assign busy_last = (cnt == CW'(WIDTH));
    assign in_ready  = (state == IDLE);

    // Two's-complement negate of the most negative value yields 2^(W-1) as unsigned.
    assign abs_a = in_a[WIDTH-1] ? -in_a : in_a;
    assign abs_b = in_b[WIDTH-1] ? -in_b : in_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = BUSY;
            BUSY: if (busy_last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
`ifdef FIXEDPOINT_MUL_ROUND_EN
        rsum = {1'b0, acc} + (SW'(1) << (FRAC - 1));
`else
        rsum = {1'b0, acc};
`endif
        m = rsum >> FRAC;
    end

    // Saturate the magnitude against the asymmetric two's-complement range, then apply sign.
    always_comb begin
        norm_data = '0;
        norm_ovf  = 1'b0;
        if (!sign) begin
            if (m > POS_MAX) begin
                norm_data = POS_MAX[WIDTH-1:0];
                norm_ovf  = 1'b1;
            end else begin
                norm_data = m[WIDTH-1:0];
            end
        end else begin
            if (m > NEG_MAX) begin
                norm_data = NEG_MAX[WIDTH-1:0];
                norm_ovf  = 1'b1;
            end else begin
                norm_data = -m[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            sign      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                        mag_a <= {{WIDTH{1'b0}}, abs_a};
                        mag_b <= abs_b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (!busy_last) begin
                        // mag_a tracks |a|<<cnt and mag_b[0] tracks bit[cnt] of |b|.
                        if (mag_b[0]) acc <= acc + mag_a;
                        mag_a <= mag_a << 1;
                        mag_b <= mag_b >> 1;
                        cnt   <= cnt + CW'(1);
                    end else begin
                        out_data  <= norm_data;
                        out_ovf   <= norm_ovf;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixedpoint_mul.sv
// tb/tb_fixedpoint_mul.sv - randomized and directed self-checking bench for fixedpoint_mul.
module tb_fixedpoint_mul;

    localparam int WIDTH = 32;
    localparam int FRAC  = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;

    fixedpoint_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product, magnitude scaled, then saturated into Q format.
    task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic ovf);
        longint p;
        longint mag;
        longint mq;
        logic   neg;
        p   = longint'($signed(a)) * longint'($signed(b));
        mag = (p < 0) ? -p : p;
`ifdef FIXEDPOINT_MUL_ROUND_EN
        mag = mag + (longint'(1) << (FRAC - 1));
`endif
        mq  = mag >>> FRAC;
        neg = a[31] ^ b[31];
        ovf = 1'b0;
        if (!neg) begin
            if (mq > 64'sh7FFF_FFFF) begin
                d = 32'h7FFF_FFFF;
                ovf = 1'b1;
            end else begin
                d = mq[31:0];
            end
        end else begin
            if (mq > 64'sh8000_0000) begin
                d = 32'h8000_0000;
                ovf = 1'b1;
            end else begin
                d = 32'(-mq);
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] got_d, output logic got_ovf);
        logic [31:0] ed;
        logic        eovf;
        logic [31:0] d0;
        logic        o0;
        logic        busy_ok;
        logic        stable;
        int          n;
        ref_mul(a, b, ed, eovf);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        busy_ok = 1'b1;
        n = 0;
        do begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = $urandom;
            in_b = $urandom;
            @(posedge clk); #1;
            n++;
            if (in_ready) busy_ok = 1'b0;
        end while (!out_valid && n < 100);
        in_valid = 1'b0;
        check("latency", 64'(n), 64'd33);
        check("busy_in_ready_low", 64'(busy_ok), 64'd1);
        check("out_data", 64'(out_data), 64'(ed));
        check("out_ovf", 64'(out_ovf), 64'(eovf));
        got_d = out_data;
        got_ovf = out_ovf;
        d0 = out_data;
        o0 = out_ovf;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_data !== d0 || out_ovf !== o0 || !out_valid || in_ready) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_return", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        o;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        spurious;
        int          n;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);

        run_op(32'h0030_0000, 32'h0040_0000, 5, d, o);
        check("dir_1p5x2", 64'({o, d}), 64'({1'b0, 32'h0060_0000}));
        run_op(32'hFFD0_0000, 32'h0040_0000, 0, d, o);
        check("dir_neg1p5x2", 64'({o, d}), 64'({1'b0, 32'hFFA0_0000}));
        run_op(32'hFFD0_0000, 32'hFFC0_0000, 1, d, o);
        check("dir_neg_neg", 64'({o, d}), 64'({1'b0, 32'h0060_0000}));
        run_op(32'h0000_0000, 32'h8000_0000, 0, d, o);
        check("dir_zero", 64'({o, d}), 64'({1'b0, 32'h0000_0000}));
        run_op(32'h7D00_0000, 32'h0080_0000, 2, d, o);
        check("dir_sat_pos", 64'({o, d}), 64'({1'b1, 32'h7FFF_FFFF}));
        run_op(32'h8000_0000, 32'h8000_0000, 0, d, o);
        check("dir_min_min", 64'({o, d}), 64'({1'b1, 32'h7FFF_FFFF}));
        run_op(32'h8000_0000, 32'h0020_0000, 0, d, o);
        check("dir_min_one", 64'({o, d}), 64'({1'b0, 32'h8000_0000}));
        run_op(32'h0000_0001, 32'h0010_0000, 0, d, o);
`ifdef FIXEDPOINT_MUL_ROUND_EN
        check("dir_round_pos", 64'({o, d}), 64'({1'b0, 32'h0000_0001}));
`else
        check("dir_round_pos", 64'({o, d}), 64'({1'b0, 32'h0000_0000}));
`endif
        run_op(32'hFFFF_FFFF, 32'h0010_0000, 0, d, o);
`ifdef FIXEDPOINT_MUL_ROUND_EN
        check("dir_round_neg", 64'({o, d}), 64'({1'b0, 32'hFFFF_FFFF}));
`else
        check("dir_round_neg", 64'({o, d}), 64'({1'b0, 32'h0000_0000}));
`endif

        for (int k = 0; k < 40; k++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_op(ra, rb, $urandom_range(0, 5), d, o);
        end

        // Make out_data nonzero, then abort a later operation mid-BUSY.
        run_op(32'h0030_0000, 32'h0040_0000, 0, d, o);
        in_a = 32'h0123_4567;
        in_b = 32'h0765_4321;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_data", 64'(out_data), 64'd0);
        spurious = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious = 1'b1;
        end
        check("abort_no_spurious", 64'(spurious), 64'd0);
        run_op(32'h0030_0000, 32'h0040_0000, 0, d, o);
        check("post_abort_1p5x2", 64'({o, d}), 64'({1'b0, 32'h0060_0000}));

        // Abort while a result is pending in DONE.
        in_a = 32'h0030_0000;
        in_b = 32'h0040_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_reached", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("done_abort_valid", 64'(out_valid), 64'd0);
        check("done_abort_ready", 64'(in_ready), 64'd1);
        check("done_abort_ovf", 64'(out_ovf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
